vgg_block_sequencer: RTL

- Top-level scheduler that runs the cascaded VGG16 convolution blocks in order.
- Issues a one-cycle start pulse to each block_2conv / block_3conv instance and waits for that block's o_valid completion pulse.
- Toggles the ping-pong feature-map buffer select between blocks.
- Reports whole-network completion, abort and error status to the host / testbench.

---
 rtl/vgg_block_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vgg_block_sequencer.sv
// Schedules the cascaded VGG16 conv blocks: start pulse, wait for done, swap ping-pong bank.
// Optional watchdog timeout enabled by defining SEQ_TIMEOUT_EN.
module vgg_block_sequencer #(
    parameter int NUM_BLOCKS     = 5,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [NUM_BLOCKS-1:0] i_blk_done,
    output logic [NUM_BLOCKS-1:0] o_blk_start,
    output logic [IDX_W-1:0]      o_cur_blk,
    output logic                  o_buf_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_SPURIOUS = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    state_t                  state, next_state;
    logic [IDX_W-1:0]        cur_blk, next_cur_blk;
    logic                    buf_sel, next_buf_sel;
    logic [1:0]              err_code, next_err_code;
    logic [NUM_BLOCKS-1:0]   cur_mask;
    logic                    cur_hit;
    logic                    spurious;
    logic                    last_blk;
    logic                    timeout_hit;

    assign cur_mask = NUM_BLOCKS'(1) << cur_blk;
    assign cur_hit  = |(i_blk_done & cur_mask);
    assign spurious = |(i_blk_done & ~cur_mask);
    assign last_blk = (cur_blk == IDX_W'(NUM_BLOCKS - 1));

`ifdef SEQ_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt;

    // Watchdog restarts on each launch and only advances while waiting on a block.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (next_state == S_LAUNCH) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == S_WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_wd_params = TIMEOUT_CYCLES + CNT_W;

    assign timeout_hit = 1'b0;
`endif

    // Abort outranks everything; a stray done outranks the expected one; a real done outranks timeout.
    always_comb begin
        next_state    = state;
        next_cur_blk  = cur_blk;
        next_buf_sel  = buf_sel;
        next_err_code = err_code;
        case (state)
            S_IDLE, S_ERROR: begin
                if (i_start) begin
                    next_state    = S_LAUNCH;
                    next_cur_blk  = '0;
                    next_buf_sel  = 1'b0;
                    next_err_code = ERR_NONE;
                end
            end
            S_LAUNCH, S_WAIT: begin
                if (i_abort) begin
                    next_state   = S_IDLE;
                    next_cur_blk = '0;
                    next_buf_sel = 1'b0;
                end else if (spurious) begin
                    next_state    = S_ERROR;
                    next_err_code = ERR_SPURIOUS;
                end else if (cur_hit) begin
                    if (last_blk) begin
                        next_state = S_FINISH;
                    end else begin
                        next_state   = S_NEXT;
                        next_cur_blk = cur_blk + IDX_W'(1);
                        next_buf_sel = ~buf_sel;
                    end
                end else if (timeout_hit) begin
                    next_state    = S_ERROR;
                    next_err_code = ERR_TIMEOUT;
                end else begin
                    next_state = S_WAIT;
                end
            end
            S_NEXT: begin
                if (i_abort) begin
                    next_state   = S_IDLE;
                    next_cur_blk = '0;
                    next_buf_sel = 1'b0;
                end else begin
                    next_state = S_LAUNCH;
                end
            end
            S_FINISH: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur_blk     <= '0;
            buf_sel     <= 1'b0;
            err_code    <= ERR_NONE;
            o_blk_start <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= next_state;
            cur_blk     <= next_cur_blk;
            buf_sel     <= next_buf_sel;
            err_code    <= next_err_code;
            o_blk_start <= (next_state == S_LAUNCH) ? (NUM_BLOCKS'(1) << next_cur_blk) : '0;
            o_busy      <= (next_state == S_LAUNCH) || (next_state == S_WAIT) ||
                           (next_state == S_NEXT)   || (next_state == S_FINISH);
            o_done      <= (next_state == S_FINISH);
            o_error     <= (next_state == S_ERROR);
        end
    end

    assign o_cur_blk  = cur_blk;
    assign o_buf_sel  = buf_sel;
    assign o_err_code = err_code;

endmodule
